// File: rtl/d_phy_slave_adapter_layer_if.sv
// Receiver FIFO write port between the D-PHY slave adapter and the CSI slave protocol layer.
// master = adapter (writer), slave = FIFO side.
interface d_phy_slave_adapter_layer_if;
    logic       wr;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       full;

    modport master (output wr, data, sop, eop, input full);
    modport slave  (input wr, data, sop, eop, output full);
endinterface

// File: rtl/d_phy_slave_adapter_layer.sv
// Single-lane D-PHY receive adapter: follows LP entry into HS, finds the sync byte,
// deserialises one CSI packet framed by its word count and writes it into the receiver FIFO.
module d_phy_slave_adapter_layer #(
    parameter int unsigned T_HS_SETTLE  = 8,
    parameter int unsigned SYNC_TIMEOUT = 64,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic                               hs_clk,
    input  logic                               rst,
    input  logic                               enable_i,
    input  logic                               lp_dp_i,
    input  logic                               lp_dn_i,
    input  logic                               hs_d_i,
    d_phy_slave_adapter_layer_if.master        fifo,
    output logic                               rx_active_o,
    output logic                               err_sync_o,
    output logic                               err_short_o,
    output logic                               err_ovf_o
);

    localparam int unsigned CntW = 16;

    typedef enum logic [2:0] {
        StStop, StHsRqst, StHsSettle, StSync, StHdr, StPayload, StTrail
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Only the 7 most recent bits are kept; the incoming bit completes the byte.
    logic [6:0]      hist_q, hist_d;
    logic [5:0]      dt_q, dt_d;
    logic [7:0]      wc_lo_q, wc_lo_d;
    logic [16:0]     rem_q, rem_d;
    logic            wr_q, wr_d, sop_q, sop_d, eop_q, eop_d, rx_q, rx_d;
    logic [7:0]      data_q, data_d;
    logic            esync_q, esync_d, eshort_q, eshort_d, eovf_q, eovf_d;

    logic [7:0] shifted;
    logic [1:0] lp;
    logic       lp_stop, byte_done, emit, emit_sop, emit_eop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        dt_d     = dt_q;
        wc_lo_d  = wc_lo_q;
        rem_d    = rem_q;
        wr_d     = 1'b0;
        data_d   = data_q;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        esync_d  = 1'b0;
        eshort_d = 1'b0;
        eovf_d   = 1'b0;
        emit     = 1'b0;
        emit_sop = 1'b0;
        emit_eop = 1'b0;

        shifted   = {hs_d_i, hist_q};
        lp        = {lp_dp_i, lp_dn_i};
        lp_stop   = (lp == 2'b11);
        byte_done = (cnt_q[2:0] == 3'd7);

        unique case (state_q)
            StStop: begin
                if (lp == 2'b01 && enable_i) state_d = StHsRqst;
            end
            StHsRqst: begin
                if (lp == 2'b00) begin
                    state_d = StHsSettle;
                    cnt_d   = '0;
                end else if (lp_dp_i) begin
                    state_d = StStop;
                end
            end
            StHsSettle: begin
                if (lp_stop) begin
                    state_d = StStop;
                end else if (cnt_q == CntW'(T_HS_SETTLE - 1)) begin
                    state_d = StSync;
                    cnt_d   = '0;
                    hist_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSync: begin
                if (lp_stop) begin
                    state_d = StStop;
                end else begin
                    hist_d = shifted[7:1];
                    cnt_d  = cnt_q + 1'b1;
                    if (shifted == SYNC_BYTE) begin
                        state_d = StHdr;
                        cnt_d   = '0;
                    end else if (cnt_q == CntW'(SYNC_TIMEOUT - 1)) begin
                        esync_d = 1'b1;
                        state_d = StTrail;
                    end
                end
            end
            StHdr: begin
                if (lp_stop) begin
                    state_d  = StStop;
                    eshort_d = 1'b1;
                end else begin
                    hist_d = shifted[7:1];
                    cnt_d  = cnt_q + 1'b1;
                    if (byte_done) begin
                        emit     = 1'b1;
                        emit_sop = (cnt_q[4:3] == 2'd0);
                        case (cnt_q[4:3])
                            2'd0: dt_d    = shifted[5:0];
                            2'd1: wc_lo_d = shifted;
                            // Payload bytes plus the two CRC bytes.
                            2'd2: rem_d   = {1'b0, shifted, wc_lo_q} + 17'd2;
                            default: begin
                                if (dt_q < 6'h10) begin
                                    emit_eop = 1'b1;
                                    state_d  = StTrail;
                                end else begin
                                    state_d = StPayload;
                                    cnt_d   = '0;
                                end
                            end
                        endcase
                    end
                end
            end
            StPayload: begin
                if (lp_stop) begin
                    state_d  = StStop;
                    eshort_d = 1'b1;
                end else begin
                    hist_d = shifted[7:1];
                    cnt_d  = cnt_q + 1'b1;
                    if (byte_done) begin
                        emit  = 1'b1;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == 17'd1) begin
                            emit_eop = 1'b1;
                            state_d  = StTrail;
                        end
                    end
                end
            end
            StTrail: begin
                if (lp_stop) state_d = StStop;
            end
            default: state_d = StStop;
        endcase

        // A full FIFO drops the byte (and any marker it carried); framing carries on.
        if (emit) begin
            if (fifo.full) begin
                eovf_d = 1'b1;
            end else begin
                wr_d   = 1'b1;
                data_d = shifted;
                sop_d  = emit_sop;
                eop_d  = emit_eop;
            end
        end

        rx_d = (state_d == StHdr) || (state_d == StPayload);
    end

    always_ff @(posedge hs_clk or posedge rst) begin
        if (rst) begin
            state_q  <= StStop;
            cnt_q    <= '0;
            hist_q   <= '0;
            dt_q     <= '0;
            wc_lo_q  <= '0;
            rem_q    <= '0;
            wr_q     <= 1'b0;
            data_q   <= 8'h00;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            rx_q     <= 1'b0;
            esync_q  <= 1'b0;
            eshort_q <= 1'b0;
            eovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
            dt_q     <= dt_d;
            wc_lo_q  <= wc_lo_d;
            rem_q    <= rem_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            rx_q     <= rx_d;
            esync_q  <= esync_d;
            eshort_q <= eshort_d;
            eovf_q   <= eovf_d;
        end
    end

    assign fifo.wr     = wr_q;
    assign fifo.data   = data_q;
    assign fifo.sop    = sop_q;
    assign fifo.eop    = eop_q;
    assign rx_active_o = rx_q;
    assign err_sync_o  = esync_q;
    assign err_short_o = eshort_q;
    assign err_ovf_o   = eovf_q;

endmodule

// File: tb/tb_d_phy_slave_adapter_layer.sv
// Bench for d_phy_slave_adapter_layer: directed and random HS bursts checked against a
// packet-level model of which bytes, markers and error pulses the FIFO side should see.
module tb_d_phy_slave_adapter_layer;

    localparam int T_SETTLE = 8;

    logic hs_clk = 1'b0;
    logic rst, enable, lp_dp, lp_dn, hs_d;
    logic rx_active, err_sync, err_short, err_ovf;

    d_phy_slave_adapter_layer_if fifo_if ();

    d_phy_slave_adapter_layer dut (
        .hs_clk      (hs_clk),
        .rst         (rst),
        .enable_i    (enable),
        .lp_dp_i     (lp_dp),
        .lp_dn_i     (lp_dn),
        .hs_d_i      (hs_d),
        .fifo        (fifo_if),
        .rx_active_o (rx_active),
        .err_sync_o  (err_sync),
        .err_short_o (err_short),
        .err_ovf_o   (err_ovf)
    );

    always #5 hs_clk = ~hs_clk;

    // Monitor: every write as {rx_active, sop, eop, data}, plus error pulse counts.
    logic [10:0] got_q[$];
    int n_sync = 0, n_short = 0, n_ovf = 0;

    always @(negedge hs_clk) begin
        if (fifo_if.wr) got_q.push_back({rx_active, fifo_if.sop, fifo_if.eop, fifo_if.data});
        if (err_sync)  n_sync++;
        if (err_short) n_short++;
        if (err_ovf)   n_ovf++;
    end

    int passes = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  pkt[$];
    logic [10:0] exp_q[$];

    // Packet: header (DT, WC lo, WC hi, ECC), WC+2 bytes for long packets, then 2 stray bytes.
    function automatic void make_pkt(input logic [5:0] dt, input logic [15:0] wc);
        int n;
        pkt.delete();
        pkt.push_back({2'b00, dt});
        pkt.push_back(wc[7:0]);
        pkt.push_back(wc[15:8]);
        pkt.push_back(8'($urandom));
        n = (dt < 6'h10) ? 0 : int'(wc) + 2;
        for (int i = 0; i < n + 2; i++) pkt.push_back(8'($urandom));
    endfunction

    task automatic set_lp(input logic [1:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge hs_clk);
            {lp_dp, lp_dn} = v;
            hs_d = 1'b0;
            fifo_if.full = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit full_last, input bit lp11_first,
                             input bit lp11_last);
        for (int i = 0; i < 8; i++) begin
            @(negedge hs_clk);
            hs_d = b[i];
            fifo_if.full = full_last && (i == 7);
            if ((lp11_first && i == 0) || (lp11_last && i == 7)) {lp_dp, lp_dn} = 2'b11;
        end
    endtask

    // mode: 0 normal, 1 lp=11 at first bit of byte 'at', 2 lp=11 on the completing bit of
    // byte 'at', 3 reset pulse while byte at-1 is being written.
    task automatic run_burst(input string name, input bit en, input int drop, input int mode,
                             input int at);
        int base, s_sync, s_short, s_ovf, flen, n, e_ovf, e_short, m;
        base    = got_q.size();
        s_sync  = n_sync;
        s_short = n_short;
        s_ovf   = n_ovf;
        enable  = en;
        set_lp(2'b11, 3);
        set_lp(2'b01, 3);
        set_lp(2'b00, T_SETTLE + 4);
        send_byte(8'hB8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < pkt.size(); i++) begin
            if (mode == 3 && i == at) begin
                @(negedge hs_clk);
                hs_d = pkt[i][0];
                #1 rst = 1'b1;
                #1;
                check({name, " rst wr"}, 32'(fifo_if.wr), 32'd0);
                check({name, " rst rx"}, 32'(rx_active), 32'd0);
                check({name, " rst data"}, 32'({fifo_if.data, fifo_if.sop, fifo_if.eop}), 32'd0);
                rst = 1'b0;
                break;
            end
            send_byte(pkt[i], i == drop, mode == 1 && i == at, mode == 2 && i == at);
            if ((mode == 1 || mode == 2) && i == at) break;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge hs_clk);
            hs_d = 1'($urandom);
            fifo_if.full = 1'b0;
        end
        set_lp(2'b11, 4);

        flen = (pkt[0][5:0] < 6'h10) ? 4 : 6 + int'({pkt[2], pkt[1]});
        n = flen;
        if (mode != 0 && at < flen) n = at;
        if (!en) n = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            if (i != drop) exp_q.push_back({i != flen - 1, i == 0, i == flen - 1, pkt[i]});
        e_ovf   = (drop >= 0 && drop < n) ? 1 : 0;
        e_short = ((mode == 1 || mode == 2) && at < flen && en) ? 1 : 0;

        check({name, " writes"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        m = (got_q.size() - base < exp_q.size()) ? got_q.size() - base : exp_q.size();
        for (int k = 0; k < m; k++) begin
            if (exp_q[k][8])
                check($sformatf("%s byte%0d", name, k), 32'(got_q[base+k][9:0]),
                      32'(exp_q[k][9:0]));
            else
                check($sformatf("%s byte%0d", name, k), 32'(got_q[base+k]), 32'(exp_q[k]));
        end
        check({name, " err_sync"}, 32'(n_sync - s_sync), 32'd0);
        check({name, " err_short"}, 32'(n_short - s_short), 32'(e_short));
        check({name, " err_ovf"}, 32'(n_ovf - s_ovf), 32'(e_ovf));
        check({name, " idle rx"}, 32'(rx_active), 32'd0);
    endtask

    initial begin
        int base, s_sync, s_short, dt, wc, flen, drop;
        rst = 1'b1;
        enable = 1'b0;
        {lp_dp, lp_dn} = 2'b11;
        hs_d = 1'b0;
        fifo_if.full = 1'b0;
        repeat (2) @(negedge hs_clk);
        check("reset wr/sop/eop", 32'({fifo_if.wr, fifo_if.sop, fifo_if.eop}), 32'd0);
        check("reset data", 32'(fifo_if.data), 32'd0);
        check("reset rx/errs", 32'({rx_active, err_sync, err_short, err_ovf}), 32'd0);
        rst = 1'b0;

        make_pkt(6'h01, 16'h0000);
        pkt[3] = 8'h07;
        run_burst("short", 1'b1, -1, 0, 0);

        make_pkt(6'h2A, 16'd3);
        run_burst("long", 1'b1, -1, 0, 0);

        // Sync timeout: zeros only after settle.
        base = got_q.size();
        s_sync = n_sync;
        s_short = n_short;
        enable = 1'b1;
        set_lp(2'b11, 3);
        set_lp(2'b01, 3);
        set_lp(2'b00, T_SETTLE + 80);
        set_lp(2'b11, 4);
        check("timeout err_sync", 32'(n_sync - s_sync), 32'd1);
        check("timeout writes", 32'(got_q.size() - base), 32'd0);
        check("timeout err_short", 32'(n_short - s_short), 32'd0);

        make_pkt(6'h24, 16'd8);
        run_burst("early stop", 1'b1, -1, 1, 6);

        make_pkt(6'h01, 16'h0000);
        pkt[3] = 8'h07;
        run_burst("overflow", 1'b1, 2, 0, 0);

        make_pkt(6'h2A, 16'd3);
        run_burst("disabled", 1'b0, -1, 0, 0);

        make_pkt(6'h2B, 16'd6);
        run_burst("reset mid", 1'b1, -1, 3, 6);

        make_pkt(6'h2A, 16'd4);
        run_burst("after reset", 1'b1, -1, 0, 0);

        make_pkt(6'h30, 16'd5);
        run_burst("stop on byte", 1'b1, -1, 2, 5);

        make_pkt(6'h22, 16'd2);
        run_burst("ovf on eop", 1'b1, 7, 0, 0);

        make_pkt(6'h05, 16'h1234);
        run_burst("short after", 1'b1, -1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            dt = $urandom_range(0, 63);
            wc = $urandom_range(0, 12);
            make_pkt(6'(dt), 16'(wc));
            flen = (dt < 16) ? 4 : wc + 6;
            drop = ($urandom_range(0, 1) == 1) ? $urandom_range(0, flen - 1) : -1;
            run_burst($sformatf("rand%0d", r), 1'b1, drop, 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
